// File: rtl/shifter_pkg.sv
// Shared encodings for the shifter family: func codes, flag bit positions,
// the sequential shifter's state encoding and a func-code validity helper.
package shifter_pkg;

    // One-hot function codes; any other pattern is treated as invalid.
    localparam logic [2:0] LOG_SHIFT = 3'b100;
    localparam logic [2:0] ARI_SHIFT = 3'b010;
    localparam logic [2:0] ROT_SHIFT = 3'b001;

    // Bit positions inside the 4-bit flag word {z, n, c, v}.
    localparam int Z = 3;
    localparam int N = 2;
    localparam int C = 1;
    localparam int V = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Only the three one-hot codes select a real operation.
    function automatic logic func_is_valid(input logic [2:0] f);
        return (f == LOG_SHIFT) || (f == ARI_SHIFT) || (f == ROT_SHIFT);
    endfunction

endpackage

// File: rtl/shift_step_1b.sv
// Single-bit shift step: moves the word one position in the requested
// direction, reports the bit that falls off and inserts the proper fill bit.
module shift_step_1b
    import shifter_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] word_i,
    input  logic              dir_i,
    input  logic [2:0]        func_i,
    output logic [DATA_W-1:0] word_o,
    output logic              out_bit_o
);

    logic fill;

    // Right shifts drop bit 0, left shifts drop the MSB; rotate recycles it.
    always_comb begin
        fill      = 1'b0;
        out_bit_o = 1'b0;
        word_o    = word_i;
        if (dir_i) begin
            out_bit_o = word_i[0];
            case (func_i)
                ARI_SHIFT: fill = word_i[DATA_W-1];
                ROT_SHIFT: fill = word_i[0];
                default:   fill = 1'b0;
            endcase
            word_o = {fill, word_i[DATA_W-1:1]};
        end else begin
            out_bit_o = word_i[DATA_W-1];
            fill      = (func_i == ROT_SHIFT) ? word_i[DATA_W-1] : 1'b0;
            word_o    = {word_i[DATA_W-2:0], fill};
        end
    end

endmodule

// File: rtl/shift_seq.sv
// Sequential shift unit: accepts one operation over valid/ready, shifts it one
// bit per clock and presents the result with {z, n, c, v} flags over
// valid/ready. Result and flags stay held until the next result is produced.
module shift_seq
    import shifter_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  data_in,
    input  logic               dir,
    input  logic [2:0]         func,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  data_out,
    output logic [3:0]         flag_out,
    output logic               busy
);

    state_t              state_q;
    logic [DATA_W-1:0]   work_q;
    logic                dir_q;
    logic [2:0]          func_q;
    logic [SHAMT_W-1:0]  count_q;
    logic [DATA_W-1:0]   data_out_q;
    logic [3:0]          flag_q;
    logic                in_ready_q;
    logic                out_valid_q;
    logic                busy_q;

    logic [DATA_W-1:0]   step_word_d;
    logic                step_bit_d;

    // Flags are always derived from the final result word and last carry.
    function automatic logic [3:0] make_flags(input logic [DATA_W-1:0] w,
                                              input logic c_bit);
        logic [3:0] f;
        f    = 4'b0000;
        f[Z] = ~|w;
        f[N] = w[DATA_W-1];
        f[C] = c_bit;
        f[V] = 1'b0;
        return f;
    endfunction

    shift_step_1b #(
        .DATA_W (DATA_W)
    ) u_step (
        .word_i    (work_q),
        .dir_i     (dir_q),
        .func_i    (func_q),
        .word_o    (step_word_d),
        .out_bit_o (step_bit_d)
    );

    // Control FSM and datapath registers; all outputs are registered here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            work_q      <= '0;
            dir_q       <= 1'b0;
            func_q      <= 3'b000;
            count_q     <= '0;
            data_out_q  <= '0;
            flag_q      <= 4'b0000;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        work_q     <= data_in;
                        dir_q      <= dir;
                        func_q     <= func;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        if ((shamt == '0) || !func_is_valid(func)) begin
                            // Nothing to shift: pass the operand through.
                            state_q     <= DONE;
                            count_q     <= '0;
                            out_valid_q <= 1'b1;
                            data_out_q  <= data_in;
                            flag_q      <= make_flags(data_in, 1'b0);
                        end else begin
                            state_q <= SHIFT;
                            count_q <= shamt;
                        end
                    end
                end
                SHIFT: begin
                    work_q  <= step_word_d;
                    count_q <= count_q - SHAMT_W'(1);
                    if (count_q == SHAMT_W'(1)) begin
                        // Last step: publish the result together with its flags.
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        data_out_q  <= step_word_d;
                        flag_q      <= make_flags(step_word_d, step_bit_d);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign data_out  = data_out_q;
    assign flag_out  = flag_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_shift_seq.sv
// Scoreboard bench for shift_seq: the driver pushes hand-computed results,
// a negedge monitor pops and compares on every output handshake.
module tb_shift_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] data_in;
    logic        dir;
    logic [2:0]  func;
    logic [4:0]  shamt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] data_out;
    logic [3:0]  flag_out;
    logic        busy;

    int total = 0;
    int bad   = 0;

    logic [35:0] exp_q[$];

    always #5 clk = ~clk;

    shift_seq #(
        .DATA_W  (32),
        .SHAMT_W (5)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .dir       (dir),
        .func      (func),
        .shamt     (shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .flag_out  (flag_out),
        .busy      (busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a result is consumed when out_valid and out_ready are both high.
    always @(negedge clk) begin
        #1;
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out: got data %0h flags %0h with empty queue",
                         data_out, flag_out);
            end else begin
                logic [35:0] e;
                e = exp_q.pop_front();
                chk("sb_data", 64'(data_out), 64'(e[35:4]));
                chk("sb_flags", 64'(flag_out), 64'(e[3:0]));
                $display("result data=%08h flags=%04b", data_out, flag_out);
            end
        end
    end

    // Issue one operation, check latency and handshake behaviour around it.
    task automatic do_op(input string name, input logic [31:0] d, input logic dr,
                         input logic [2:0] f, input logic [4:0] sh,
                         input logic [31:0] ed, input logic [3:0] ef,
                         input int elat, input int stall);
        int  cyc;
        int  busy_err;
        bit  seen;
        @(negedge clk);
        chk({name, "_ready_idle"}, 64'(in_ready), 64'd1);
        data_in   = d;
        dir       = dr;
        func      = f;
        shamt     = sh;
        in_valid  = 1'b1;
        out_ready = (stall == 0);
        exp_q.push_back({ed, ef});
        @(posedge clk);
        cyc      = 1;
        seen     = 0;
        busy_err = 0;
        @(negedge clk);
        in_valid = 1'b0;
        // Scramble operands: they must be ignored once the op is latched.
        data_in  = ~d;
        dir      = ~dr;
        func     = 3'b111;
        shamt    = ~sh;
        while (!seen && cyc < 100) begin
            if (out_valid) begin
                seen = 1;
            end else begin
                if (in_ready !== 1'b0 || busy !== 1'b1) busy_err++;
                @(negedge clk);
                cyc++;
            end
        end
        chk({name, "_latency"}, 64'(seen ? cyc : -1), 64'(elat));
        chk({name, "_busy_shift"}, 64'(busy_err), 64'd0);
        chk({name, "_done_ctrl"}, 64'({in_ready, busy}), 64'(2'b01));
        if (stall > 0) begin
            for (int i = 0; i < stall; i++) begin
                if (i == 1) begin
                    in_valid = 1'b1;
                    data_in  = 32'h1234_5678;
                    func     = 3'b011;
                    shamt    = 5'd0;
                end else begin
                    in_valid = 1'b0;
                end
                @(negedge clk);
                chk({name, "_stall_hold"},
                    64'({out_valid, in_ready, data_out, flag_out}),
                    64'({1'b1, 1'b0, ed, ef}));
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        chk({name, "_after"}, 64'({out_valid, in_ready, busy}), 64'(3'b010));
        chk({name, "_hold_out"}, 64'({data_out, flag_out}), 64'({ed, ef}));
        $display("op %s d=%08h dir=%0d func=%03b shamt=%0d latency=%0d",
                 name, d, dr, f, sh, cyc);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        data_in   = 32'h0;
        dir       = 1'b0;
        func      = 3'b000;
        shamt     = 5'd0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_state", 64'({in_ready, out_valid, busy, data_out, flag_out}),
            64'({1'b1, 1'b0, 1'b0, 32'h0, 4'h0}));
        reset = 1'b0;

        do_op("lsr1",  32'h8000_0001, 1'b1, 3'b100, 5'd1,  32'h4000_0000, 4'b0010, 2,  0);
        do_op("asr31", 32'h8000_0000, 1'b1, 3'b010, 5'd31, 32'hFFFF_FFFF, 4'b0100, 32, 0);
        do_op("ror1",  32'h0000_0001, 1'b1, 3'b001, 5'd1,  32'h8000_0000, 4'b0110, 2,  0);
        do_op("rol4",  32'h8000_0001, 1'b0, 3'b001, 5'd4,  32'h0000_0018, 4'b0000, 5,  0);
        do_op("lsl1",  32'h8000_0000, 1'b0, 3'b100, 5'd1,  32'h0000_0000, 4'b1010, 2,  0);
        do_op("inval", 32'h1234_5678, 1'b1, 3'b011, 5'd7,  32'h1234_5678, 4'b0000, 1,  0);
        do_op("sh0",   32'hF000_0000, 1'b1, 3'b100, 5'd0,  32'hF000_0000, 4'b0100, 1,  0);
        do_op("asl2",  32'hC000_0001, 1'b0, 3'b010, 5'd2,  32'h0000_0004, 4'b0010, 3,  0);
        do_op("bp",    32'h0000_00F0, 1'b1, 3'b001, 5'd5,  32'h8000_0007, 4'b0110, 6,  5);

        // The pulse offered during backpressure must not have been taken.
        repeat (2) @(negedge clk);
        chk("bp_no_accept", 64'({out_valid, busy, in_ready}), 64'(3'b001));

        // Abort a shamt-10 operation during its third SHIFT cycle.
        @(negedge clk);
        data_in  = 32'hAAAA_5555;
        dir      = 1'b1;
        func     = 3'b100;
        shamt    = 5'd10;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("abort_busy", 64'({busy, in_ready}), 64'(2'b10));
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_state", 64'({in_ready, out_valid, busy, flag_out, data_out}),
            64'({1'b1, 1'b0, 1'b0, 4'h0, 32'h0}));
        reset = 1'b0;
        $display("op abort shamt=10 reset during third shift cycle");

        do_op("post",  32'h8000_000F, 1'b1, 3'b010, 5'd3,  32'hF000_0001, 4'b0110, 4,  0);

        repeat (2) @(negedge clk);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
